// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: aligned multi-instruction requests, epoch-tagged in-flight
// tracking and a decoupled instruction queue feeding ID. Optional counters: IF_PERF_CNT_EN.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'hbfc0_0000,
  parameter int FETCH_N = 2,
  parameter int QDEPTH  = 8,
  parameter int MAX_OS  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  input  logic [31:0]          flush_pc,
  input  logic                 br_e,
  input  logic [31:0]          br_addr,
  output logic                 req,
  output logic [31:0]          addr,
  input  logic                 addr_ok,
  input  logic [32*FETCH_N-1:0] rdata,
  input  logic                 data_ok,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_pc,
  output logic [31:0]          out_inst,
  output logic [31:0]          perf_req_cnt,
  output logic [31:0]          perf_drop_cnt
);

  localparam int QW = $clog2(QDEPTH);
  localparam int CW = QW + 1;
  localparam int TW = (MAX_OS > 1) ? $clog2(MAX_OS) : 1;
  localparam int OW = $clog2(MAX_OS + 1);
  localparam logic [31:0] LINE_BYTES = 32'(FETCH_N * 4);
  localparam logic [31:0] ALIGN_MASK = ~(LINE_BYTES - 32'd1);

  logic [31:0]   fetch_pc_r;
  logic          epoch_r;
  logic [OW-1:0] os_cnt_r;
  logic          hold_r, hold_ep_r, hold_stale_r;
  logic [31:0]   hold_pc_r;
  logic [31:0]   tag_pc_r   [MAX_OS];
  logic          tag_ep_r   [MAX_OS];
  logic          tag_kill_r [MAX_OS];
  logic [TW-1:0] tag_wr_r, tag_rd_r;
  logic [31:0]   q_pc_r   [QDEPTH];
  logic [31:0]   q_inst_r [QDEPTH];
  logic [QW-1:0] q_wr_r, q_rd_r;
  logic [CW-1:0] q_cnt_r;

  logic          redirect_s, can_issue_s, space_ok_s, accept_s, resp_s, keep_s, drop_s, pop_s;
  logic          req_ep_s;
  logic [31:0]   target_s, req_pc_s, head_pc_s, base_s, off_s, n_wr_s;
  logic [CW-1:0] free_s;

  function automatic logic [TW-1:0] tag_inc(input logic [TW-1:0] p);
    if (p == TW'(MAX_OS - 1)) return {TW{1'b0}};
    else return p + TW'(1);
  endfunction

  assign redirect_s  = flush | br_e;
  assign target_s    = flush ? flush_pc : br_addr;
  assign free_s      = CW'(QDEPTH) - q_cnt_r;
  // Every in-flight request already owns FETCH_N queue slots, so overflow cannot occur.
  assign space_ok_s  = (32'(free_s) >= 32'(FETCH_N) * (32'(os_cnt_r) + 32'd1));
  assign can_issue_s = ~stall & ~redirect_s & (32'(os_cnt_r) < 32'(MAX_OS)) & space_ok_s;
  assign req         = ~rst & (hold_r | can_issue_s);
  assign req_pc_s    = hold_r ? hold_pc_r : fetch_pc_r;
  assign req_ep_s    = hold_r ? hold_ep_r : epoch_r;
  assign addr        = req_pc_s & ALIGN_MASK;
  assign accept_s    = req & addr_ok;

  assign resp_s    = data_ok & (os_cnt_r != {OW{1'b0}});
  assign head_pc_s = tag_pc_r[tag_rd_r];
  assign base_s    = head_pc_s & ALIGN_MASK;
  assign off_s     = (head_pc_s >> 2) & 32'(FETCH_N - 1);
  assign n_wr_s    = 32'(FETCH_N) - off_s;
  assign keep_s    = resp_s & (tag_ep_r[tag_rd_r] == epoch_r) & ~tag_kill_r[tag_rd_r] & ~redirect_s;
  assign drop_s    = resp_s & ~keep_s;

  assign out_valid = (q_cnt_r != {CW{1'b0}}) & ~redirect_s;
  assign pop_s     = out_valid & out_ready;
  assign out_pc    = q_pc_r[q_rd_r];
  assign out_inst  = q_inst_r[q_rd_r];

  // Fetch PC and the request held on the bus until accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_r   <= RESET_PC;
      hold_r       <= 1'b0;
      hold_pc_r    <= RESET_PC;
      hold_ep_r    <= 1'b0;
      hold_stale_r <= 1'b0;
    end else begin
      if (redirect_s) begin
        fetch_pc_r <= target_s;
      end else if (accept_s & ~(hold_r & hold_stale_r)) begin
        fetch_pc_r <= (req_pc_s & ALIGN_MASK) + LINE_BYTES;
      end
      if (req & ~addr_ok) begin
        hold_r       <= 1'b1;
        hold_pc_r    <= req_pc_s;
        hold_ep_r    <= req_ep_s;
        hold_stale_r <= (hold_r & hold_stale_r) | redirect_s;
      end else begin
        hold_r       <= 1'b0;
        hold_stale_r <= 1'b0;
      end
    end
  end

  // In-flight tag FIFO, outstanding count and epoch; a redirect also kills all live tags.
  always_ff @(posedge clk) begin
    if (rst) begin
      epoch_r  <= 1'b0;
      os_cnt_r <= {OW{1'b0}};
      tag_wr_r <= {TW{1'b0}};
      tag_rd_r <= {TW{1'b0}};
      for (int i = 0; i < MAX_OS; i++) tag_kill_r[i] <= 1'b0;
    end else begin
      if (redirect_s) begin
        epoch_r <= ~epoch_r;
        for (int i = 0; i < MAX_OS; i++) tag_kill_r[i] <= 1'b1;
      end
      if (accept_s) begin
        tag_pc_r[tag_wr_r]   <= req_pc_s;
        tag_ep_r[tag_wr_r]   <= req_ep_s;
        tag_kill_r[tag_wr_r] <= redirect_s | (hold_r & hold_stale_r);
        tag_wr_r             <= tag_inc(tag_wr_r);
      end
      if (resp_s) tag_rd_r <= tag_inc(tag_rd_r);
      os_cnt_r <= os_cnt_r + OW'(accept_s) - OW'(resp_s);
    end
  end

  // Instruction queue: multi-entry write of the useful slots, single pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_wr_r  <= {QW{1'b0}};
      q_rd_r  <= {QW{1'b0}};
      q_cnt_r <= {CW{1'b0}};
      for (int i = 0; i < QDEPTH; i++) begin
        q_pc_r[i]   <= 32'd0;
        q_inst_r[i] <= 32'd0;
      end
    end else if (redirect_s) begin
      q_wr_r  <= {QW{1'b0}};
      q_rd_r  <= {QW{1'b0}};
      q_cnt_r <= {CW{1'b0}};
    end else begin
      if (keep_s) begin
        for (int i = 0; i < FETCH_N; i++) begin
          if (32'(i) >= off_s) begin
            q_pc_r[q_wr_r + QW'(i) - QW'(off_s)]   <= base_s + 32'(4 * i);
            q_inst_r[q_wr_r + QW'(i) - QW'(off_s)] <= rdata[32*i +: 32];
          end
        end
        q_wr_r <= q_wr_r + QW'(n_wr_s);
      end
      q_rd_r  <= q_rd_r + QW'(pop_s);
      q_cnt_r <= q_cnt_r + (keep_s ? CW'(n_wr_s) : {CW{1'b0}}) - CW'(pop_s);
    end
  end

`ifdef IF_PERF_CNT_EN
  logic [31:0] perf_req_r, perf_drop_r;

  // Accepted-request and discarded-response counters, wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_req_r  <= 32'd0;
      perf_drop_r <= 32'd0;
    end else begin
      if (accept_s) perf_req_r <= perf_req_r + 32'd1;
      if (drop_s) perf_drop_r <= perf_drop_r + 32'd1;
    end
  end

  assign perf_req_cnt  = perf_req_r;
  assign perf_drop_cnt = perf_drop_r;
`else
  assign perf_req_cnt  = 32'd0;
  assign perf_drop_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue: bus/memory model plus a PC-stream scoreboard.
module tb_if_fetch_queue;
  localparam int FN = 2;
  localparam logic [31:0] RPC = 32'hbfc0_0000;

  logic clk = 1'b0;
  logic rst, stall, flush, br_e, addr_ok, data_ok, out_ready, req, out_valid;
  logic [31:0] flush_pc, br_addr, addr, out_pc, out_inst, perf_req_cnt, perf_drop_cnt;
  logic [32*FN-1:0] rdata;

  always #5 clk = ~clk;

  if_fetch_queue #(.RESET_PC(RPC), .FETCH_N(FN), .QDEPTH(8), .MAX_OS(2)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush), .flush_pc(flush_pc),
    .br_e(br_e), .br_addr(br_addr), .req(req), .addr(addr), .addr_ok(addr_ok),
    .rdata(rdata), .data_ok(data_ok), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_inst(out_inst), .perf_req_cnt(perf_req_cnt),
    .perf_drop_cnt(perf_drop_cnt)
  );

  typedef struct {
    logic [31:0] a;
    int due;
    int ep;
  } bus_t;

  bus_t        bus_q[$];
  logic [31:0] exp_q[$];
  int total = 0, bad = 0, cyc = 0, lat = 1, bench_ep = 0, hs_cnt = 0, n_acc = 0, n_drop = 0;
  int h0, d0, hold_ep;
  bit acc_en = 1'b1, hold_v = 1'b0;
  logic [31:0] hold_a;

  function automatic logic [31:0] mk(input logic [31:0] pc);
    return pc ^ 32'hdead_beef;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic push_stream(input logic [31:0] start, input int n);
    exp_q.delete();
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(4 * i));
  endtask

  // One clock: drive bus, observe outputs, update models, advance past the edge.
  task automatic tick();
    bus_t b;
    logic [31:0] e;
    if (bus_q.size() > 0 && bus_q[0].due <= cyc) begin
      data_ok = 1'b1;
      for (int i = 0; i < FN; i++) rdata[32*i +: 32] = mk(bus_q[0].a + 32'(4 * i));
    end else begin
      data_ok = 1'b0;
      rdata = '0;
    end
    addr_ok = acc_en;
    if (flush || br_e) bench_ep++;
    #1;
    if (flush || br_e) chk("valid_in_redirect", 32'(out_valid), 32'd0);
    if (hold_v) begin
      chk("hold_req", 32'(req), 32'd1);
      chk("hold_addr", addr, hold_a);
    end
    if (req) chk("addr_align", addr & 32'(FN * 4 - 1), 32'd0);
    if (req && addr_ok) begin
      b.a = addr; b.due = cyc + lat; b.ep = hold_v ? hold_ep : bench_ep;
      bus_q.push_back(b);
      n_acc++;
      hold_v = 1'b0;
    end else if (req && !hold_v) begin
      hold_v = 1'b1; hold_a = addr; hold_ep = bench_ep;
    end
    if (data_ok) begin
      if (bus_q[0].ep != bench_ep) n_drop++;
      void'(bus_q.pop_front());
    end
    if (out_valid && out_ready) begin
      hs_cnt++;
      if (exp_q.size() == 0) begin
        total++; bad++;
        $error("FAIL sb_underflow observed=%h expected=none", out_pc);
      end else begin
        e = exp_q.pop_front();
        chk("out_pc", out_pc, e);
        chk("out_inst", out_inst, mk(e));
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; br_e = 1'b0; flush_pc = 32'd0; br_addr = 32'd0;
    out_ready = 1'b1; addr_ok = 1'b0; data_ok = 1'b0; rdata = '0;
    repeat (3) tick();
    chk("rst_req", 32'(req), 32'd0);
    chk("rst_addr", addr, RPC);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_inst", out_inst, 32'd0);
    chk("rst_perf_req", perf_req_cnt, 32'd0);
    chk("rst_perf_drop", perf_drop_cnt, 32'd0);

    // Zero-latency memory streaming from the reset PC
    push_stream(RPC, 400);
    rst = 1'b0;
    #1;
    chk("first_req", 32'(req), 32'd1);
    repeat (10) tick();
    h0 = hs_cnt;
    repeat (20) tick();
    chk("stream_rate", 32'(hs_cnt - h0), 32'd20);

    // Branch into the middle of a fetch line
    br_addr = 32'h8000_0104; br_e = 1'b1;
    push_stream(32'h8000_0104, 400);
    tick();
    br_e = 1'b0;
    h0 = hs_cnt;
    repeat (15) tick();
    chk("br_progress", 32'(hs_cnt - h0 >= 10), 32'd1);

    // Redirect with two requests outstanding
    lat = 4;
    for (int k = 0; k < 20 && bus_q.size() < 2; k++) tick();
    chk("os_reach2", 32'(bus_q.size()), 32'd2);
    d0 = n_drop;
    br_addr = 32'h8000_1000; br_e = 1'b1;
    push_stream(32'h8000_1000, 400);
    tick();
    br_e = 1'b0;
    repeat (20) tick();
    chk("drop_two", 32'(n_drop - d0), 32'd2);

    // Drain, then back-pressure until the queue is full
    lat = 1; stall = 1'b1;
    repeat (10) tick();
    chk("drained_valid", 32'(out_valid), 32'd0);
    stall = 1'b0; out_ready = 1'b0;
    repeat (20) tick();
    chk("full_req", 32'(req), 32'd0);
    chk("full_valid", 32'(out_valid), 32'd1);
    stall = 1'b1; out_ready = 1'b1;
    h0 = hs_cnt;
    repeat (12) tick();
    chk("drain_count", 32'(hs_cnt - h0), 32'd8);
    chk("drain_empty", 32'(out_valid), 32'd0);

    // Held request across simultaneous flush and branch
    stall = 1'b0; acc_en = 1'b0;
    repeat (3) tick();
    flush = 1'b1; br_e = 1'b1; flush_pc = 32'h0040_0020; br_addr = 32'h9000_0000;
    push_stream(32'h0040_0020, 400);
    tick();
    flush = 1'b0; br_e = 1'b0;
    repeat (2) tick();
    acc_en = 1'b1;
    h0 = hs_cnt;
    repeat (20) tick();
    chk("flush_progress", 32'(hs_cnt - h0 >= 10), 32'd1);

    // Stall with MAX_OS requests in flight
    lat = 3;
    for (int k = 0; k < 20 && bus_q.size() < 2; k++) tick();
    chk("stall_os2", 32'(bus_q.size()), 32'd2);
    stall = 1'b1;
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("stall_req", 32'(req), 32'd0);
    end
    chk("stall_bus_empty", 32'(bus_q.size()), 32'd0);

`ifdef IF_PERF_CNT_EN
    chk("perf_req", perf_req_cnt, 32'(n_acc));
    chk("perf_drop", perf_drop_cnt, 32'(n_drop));
`else
    chk("perf_req", perf_req_cnt, 32'd0);
    chk("perf_drop", perf_drop_cnt, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Parametrised instruction-fetch stage with decoupled fetch buffer. Generates aligned fetch addresses, issues multi-instruction requests over a split address/data SRAM-like bus with up to MAX_OS outstanding transactions, and buffers returned instructions in a FIFO that feeds ID one instruction per cycle. Handles flush and branch redirects by epoch-tagging in-flight requests and discarding stale responses. Sits between the PC/redirect logic (CTRL, EX branch bus) and ID.

## Interface
Parameters:
- RESET_PC, 32'hbfc0_0000, first fetch PC after reset (word aligned)
- FETCH_N, 2, instructions per request; power of 2, 1..4
- QDEPTH, 8, instruction queue entries; power of 2, ≥ FETCH_N*MAX_OS
- MAX_OS, 2, max outstanding requests; 1..4

Ports (reset rst, synchronous, active-high; clock clk):
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- stall  in  1  1 = issue no new requests (accepted ones still complete)
- flush  in  1  exception redirect, priority over br_e
- flush_pc  in  32  flush target
- br_e  in  1  branch redirect
- br_addr  in  32  branch target
- req  out  1  fetch request valid
- addr  out  32  fetch address, aligned to FETCH_N*4 bytes
- addr_ok  in  1  request accepted this cycle
- rdata  in  32*FETCH_N  response; instruction i in bits [32i+31:32i]
- data_ok  in  1  response valid this cycle (in order)
- out_valid  out  1  instruction available to ID
- out_ready  in  1  ID consumes head when out_valid
- out_pc  out  32  PC of head instruction
- out_inst  out  32  head instruction
- perf_req_cnt  out  32  accepted requests (see Configuration)
- perf_drop_cnt  out  32  discarded responses (see Configuration)

## Operation
- fetch_pc register: exact next PC; addr = fetch_pc with low log2(FETCH_N*4) bits cleared; slot offset = fetch_pc[log2(FETCH_N)+1:2].
- Issue condition: ~stall, ~redirect, os_cnt < MAX_OS, free queue entries ≥ FETCH_N*(os_cnt+1) (space reserved for all in-flight).
- Once req asserted, req and addr stay stable until addr_ok, even across stall or redirect.
- On addr_ok: push {epoch, offset} into tag FIFO (depth MAX_OS), os_cnt+1, fetch_pc ← addr + FETCH_N*4 (offset 0), unless redirect that cycle.
- Redirect (flush | br_e): target = flush ? flush_pc : br_addr; fetch_pc ← target; epoch toggles; queue emptied. Request pending without addr_ok at redirect completes with old address, tagged old epoch.
- On data_ok: pop tag FIFO, os_cnt−1. Tag epoch == current epoch and no redirect this cycle → write instructions offset..FETCH_N−1 into queue, pc = addr_base + 4*i. Otherwise discard all.
- data_ok with empty tag FIFO: ignored.
- os_cnt simultaneous +1/−1 nets to zero change.
- Queue: circular, pointers wrap mod QDEPTH; write of up to FETCH_N entries and pop of 1 in same cycle allowed; reservation makes overflow impossible.
- out_valid = (count != 0) & ~flush & ~br_e; out_pc/out_inst = head entry.

## Timing
- Reset values: req 0, addr RESET_PC aligned, out_valid 0, out_pc/out_inst 0, counters 0, epoch 0, os_cnt 0, queue empty, fetch_pc RESET_PC.
- First req: first cycle after rst deasserts.
- data_ok at edge t → out_valid 1 in cycle t+1 (registered write); no bypass.
- addr_ok combinational allowed in same cycle req rises; next req may issue cycle after.
- Redirect at cycle t: first new-target req at t+1 if no stale req pending; queue empty at t+1.
- Reset mid-operation: all state cleared next edge; bus assumed reset simultaneously.

## Configuration
- IF_PERF_CNT_EN defined: perf_req_cnt increments on each req&addr_ok, perf_drop_cnt on each discarded data_ok; both wrap at 2^32, cleared by rst.
- Not defined: both ports tied to 0, no counter flops.

## Test plan
- Reset then zero-latency memory (addr_ok=1, data_ok next cycle), out_ready=1 → out_pc sequence bfc00000, bfc00004, bfc00008… one per cycle after startup.
- br_e to 0x8000_0104 with FETCH_N=2 → first out_pc 0x8000_0104, slot 0 of that response dropped, next out_pc 0x8000_0108.
- Redirect while two requests outstanding → both responses discarded, perf_drop_cnt=2, no stale out_pc reaches ID.
- out_ready=0 for 20 cycles → req stops once queue reservation full, count=QDEPTH, no entry lost; release → in-order drain.
- flush and br_e same cycle → flush_pc wins; request pending without addr_ok across redirect keeps addr stable until accepted.
- stall=1 with MAX_OS requests in flight → no new req, in-flight data still enters queue.
